uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that lets the CORES mini16 cores share the SoC's single UART transmitter. Each core presents a byte with a request/acknowledge handshake. The arbiter picks one requester, latches its byte, drives the transmitter's `start`/`data_tx` inputs, and tracks `busy` until the byte is on the wire. It sits in mini16_soc between the per-core I/O register write ports and the `uart` instance.

## Interface
Parameters:
- `CORES`, 4, number of requesting cores.
- `IDX_BITS`, 2, width of a core index; must satisfy 2^IDX_BITS >= CORES.
- `WIDTH`, 8, byte width; must match the transmitter's `WIDTH`.
- `BUSY_TIMEOUT`, 15, cycles to wait for `busy` to rise after `start`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `req`  in  CORES  bit i high means core i has a byte pending.
- `data`  in  CORES*WIDTH  byte of core i in bits [i*WIDTH +: WIDTH].
- `ack`  out  CORES  one-cycle pulse on bit i when core i's byte has been latched.
- `uart_start`  out  1  one-cycle start pulse to the transmitter.
- `uart_data_tx`  out  WIDTH  latched byte; stable from `uart_start` until return to IDLE.
- `uart_busy`  in  1  transmitter busy.
- `grant_id`  out  IDX_BITS  index of the current or most recent grantee.
- `active`  out  1  high while not in IDLE.
- `timeout_err`  out  1  sticky; set when `busy` never rose.

## Operation
- States are IDLE, WAIT_BUSY and WAIT_DONE.
- **IDLE:** `req` is sampled only in this state. If any bit is set, the winner is the first set bit searching upward (cyclically) from `last+1`, where `last` is the previous grantee. On that edge:
  - `uart_data_tx` <= data[winner]
  - `grant_id` <= winner
  - `last` <= winner
  - `ack[winner]` <= 1
  - `uart_start` <= 1
  - state <= WAIT_BUSY
- **WAIT_BUSY:**
  - `uart_start` and `ack` return to 0 after one cycle.
  - When `uart_busy` = 1: go to WAIT_DONE.
  - When the wait counter reaches BUSY_TIMEOUT with no `busy`: set `timeout_err` and go to IDLE. The byte is dropped; it is not retried.
- **WAIT_DONE:** on `uart_busy` = 0, go to IDLE.
- **Requester side:** an `ack` means the byte was consumed. A requester may hold `req` high and change `data` in the cycle after `ack` to send its next byte. That next byte competes normally, with this core now lowest priority.
- **Reset values:**
  - `ack`, `uart_start`, `uart_data_tx`, `grant_id`, `active`, `timeout_err`: all 0.
  - State: IDLE.
  - `last` = CORES-1, so core 0 wins first.
- **Reset mid-transfer:** return to IDLE immediately and clear `timeout_err`. A transfer already in the transmitter completes on its own. The arbiter starts fresh and waits for `busy` only through the new handshake.
- **Width and wrap rules:**
  - The rotation index wraps modulo CORES, not 2^IDX_BITS.
  - The timeout counter is $clog2(BUSY_TIMEOUT+1) bits, cleared on entry to WAIT_BUSY.

## Timing
- Request to `uart_start`/`ack`: 1 cycle; registered outputs are visible the cycle after `req` is seen in IDLE.
- `busy` already high on entry to WAIT_BUSY (e.g. a held-over transfer): go straight to WAIT_DONE on the next edge.
- End of transfer: `busy` falling to 0 gives IDLE on the next edge. A new grant can be issued one cycle after that, so the minimum inter-byte gap from `busy` falling is 2 cycles.
- `req` deasserted between sampling and `ack`: irrelevant, because the byte is already latched.
- All cores requesting continuously: grants follow 0,1,2,3,0…
- Worst-case latency for any core: (CORES-1) full transfers plus 2 cycles each.

## Structure
- A shared package `mini16_uart_pkg` holds:
  - the state encoding constants (`ARB_IDLE`, `ARB_WAIT_BUSY`, `ARB_WAIT_DONE`);
  - the default BUSY_TIMEOUT.
- One sub-module is natural: `rr_select`. It is purely combinational; inputs are `req` and `last`, outputs are `winner` and `any`. It is reusable for the future shared-memory arbiter.
- Everything else is a single sequential always-block in `uart_tx_arbiter`.

## Test plan
Benches use a `busy` model that rises 2 cycles after `start` and stays high for 20 cycles.
- **Single requester:** `req`=4'b0001 with byte 0x41 → `uart_start` and `ack`[0] pulse 1 cycle later, `uart_data_tx`=0x41, `grant_id`=0.
- **All four requesting continuously:** bytes 0x30–0x33 → transmitted order 0x30,0x31,0x32,0x33,0x30; exactly one `ack` per transfer.
- **Core 2 streaming "ABC":** core 2 holds `req` and advances `data` after each `ack`; core 1 requests once mid-stream → sequence A,B,(core1),C. Core 1 is granted at the first IDLE after its request.
- **Timeout:** `busy` tied low → `timeout_err` rises exactly BUSY_TIMEOUT cycles after `uart_start`; state returns to IDLE; the next request is still served.
- **Reset mid-transfer:** assert `reset` in WAIT_DONE → all outputs are 0 and `active`=0 on the next cycle; the first post-reset grant goes to core 0.
- **Integration:** full mini16_soc with UART_CLK_HZ=50 MHz and UART_SCLK_HZ=5 MHz → the receive-side `uart` emits bytes that match each core's output stream, with no lost or duplicated characters.

Source files
------------

// File: rtl/mini16_uart_pkg.sv
// Shared definitions for the mini16 UART transmit path: arbiter state
// encoding and the default wait for the transmitter to report busy.
package mini16_uart_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_WAIT_BUSY = 2'd1,
        ARB_WAIT_DONE = 2'd2
    } arb_state_t;

    localparam int DEFAULT_BUSY_TIMEOUT = 15;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: first set request searching upward from
// last+1, wrapping modulo CORES. Shared with the future memory arbiter.
module rr_select #(
    parameter int CORES    = 4,
    parameter int IDX_BITS = 2
) (
    input  logic [CORES-1:0]    req,
    input  logic [IDX_BITS-1:0] last,
    output logic [IDX_BITS-1:0] winner,
    output logic                any
);

    always_comb begin : pick
        int                  w_idx;
        logic [IDX_BITS-1:0] w_idx_b;
        winner  = last;
        w_idx   = 0;
        w_idx_b = '0;
        // Walk from the farthest candidate down so the nearest one wins last.
        for (int k = CORES; k >= 1; k--) begin
            w_idx = int'(last) + k;
            if (w_idx >= CORES) begin
                w_idx = w_idx - CORES;
            end
            w_idx_b = IDX_BITS'(w_idx);
            if (req[w_idx_b]) begin
                winner = w_idx_b;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of the single UART transmitter between CORES cores:
// grants one byte per handshake and tracks transmitter busy until done.
module uart_tx_arbiter
    import mini16_uart_pkg::*;
#(
    parameter int CORES        = 4,
    parameter int IDX_BITS     = 2,
    parameter int WIDTH        = 8,
    parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [CORES-1:0]       req,
    input  logic [CORES*WIDTH-1:0] data,
    output logic [CORES-1:0]       ack,
    output logic                   uart_start,
    output logic [WIDTH-1:0]       uart_data_tx,
    input  logic                   uart_busy,
    output logic [IDX_BITS-1:0]    grant_id,
    output logic                   active,
    output logic                   timeout_err
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    arb_state_t          r_state;
    arb_state_t          w_state_next;
    logic [IDX_BITS-1:0] r_last;
    logic [CNT_W-1:0]    r_cnt;
    logic [CORES-1:0]    r_ack;
    logic                r_start;
    logic [WIDTH-1:0]    r_data_tx;
    logic [IDX_BITS-1:0] r_grant_id;
    logic                r_timeout_err;

    logic [IDX_BITS-1:0] w_winner;
    logic                w_any;
    logic                w_timeout_hit;
    logic                w_grant;
    logic                w_timeout_set;
    logic [WIDTH-1:0]    w_bytes [CORES];

    for (genvar gi = 0; gi < CORES; gi++) begin : g_bytes
        assign w_bytes[gi] = data[gi*WIDTH +: WIDTH];
    end

    rr_select #(
        .CORES    (CORES),
        .IDX_BITS (IDX_BITS)
    ) u_rr_select (
        .req    (req),
        .last   (r_last),
        .winner (w_winner),
        .any    (w_any)
    );

    // Counter holds the number of edges already spent in WAIT_BUSY.
    assign w_timeout_hit = (r_cnt == CNT_W'(BUSY_TIMEOUT - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_any) w_state_next = ARB_WAIT_BUSY;
            end
            ARB_WAIT_BUSY: begin
                if (uart_busy)          w_state_next = ARB_WAIT_DONE;
                else if (w_timeout_hit) w_state_next = ARB_IDLE;
            end
            ARB_WAIT_DONE: begin
                if (!uart_busy) w_state_next = ARB_IDLE;
            end
            default: w_state_next = ARB_IDLE;
        endcase
    end

    always_comb begin
        w_grant       = (r_state == ARB_IDLE) && w_any;
        w_timeout_set = (r_state == ARB_WAIT_BUSY) && !uart_busy && w_timeout_hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ARB_IDLE;
            r_last        <= IDX_BITS'(CORES - 1);
            r_cnt         <= '0;
            r_ack         <= '0;
            r_start       <= 1'b0;
            r_data_tx     <= '0;
            r_grant_id    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_start <= w_grant;
            r_ack   <= w_grant ? (CORES'(1) << w_winner) : '0;
            if (w_grant) begin
                r_data_tx  <= w_bytes[w_winner];
                r_grant_id <= w_winner;
                r_last     <= w_winner;
                r_cnt      <= '0;
            end else if (r_state == ARB_WAIT_BUSY) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_timeout_set) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign ack          = r_ack;
    assign uart_start   = r_start;
    assign uart_data_tx = r_data_tx;
    assign grant_id     = r_grant_id;
    assign active       = (r_state != ARB_IDLE);
    assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued requesters, a busy model (rise 2 cycles
// after start, high 20 cycles) and a cycle-level reference of the arbiter.
module tb_uart_tx_arbiter;

    localparam int CORES    = 4;
    localparam int IDX_BITS = 2;
    localparam int WIDTH    = 8;
    localparam int BT       = 15;
    localparam int M_IDLE   = 0;
    localparam int M_WB     = 1;
    localparam int M_WD     = 2;
    localparam int QD       = 128;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [CORES-1:0]       req;
    logic [CORES*WIDTH-1:0] data;
    logic [CORES-1:0]       ack;
    logic                   uart_start;
    logic [WIDTH-1:0]       uart_data_tx;
    logic                   uart_busy;
    logic [IDX_BITS-1:0]    grant_id;
    logic                   active;
    logic                   timeout_err;

    uart_tx_arbiter #(
        .CORES        (CORES),
        .IDX_BITS     (IDX_BITS),
        .WIDTH        (WIDTH),
        .BUSY_TIMEOUT (BT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .data         (data),
        .ack          (ack),
        .uart_start   (uart_start),
        .uart_data_tx (uart_data_tx),
        .uart_busy    (uart_busy),
        .grant_id     (grant_id),
        .active       (active),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // requester queues
    logic [WIDTH-1:0] qbuf [CORES][QD];
    int qhead [CORES];
    int qtail [CORES];

    // reference model of the arbiter
    int               m_phase;
    int               m_n;
    int               m_last;
    logic             m_err;
    logic [WIDTH-1:0] m_data;
    int               m_gid;

    // transmitter busy model
    int   bt;
    logic busy_en;

    // observed grants
    int               log_core [$];
    logic [WIDTH-1:0] log_byte [$];
    int               log_cyc  [$];
    int               ack_cnt;
    int               err_tick;
    int               start_tick;
    logic             err_seen;

    int               inj_core;
    int               inj_at;
    logic [WIDTH-1:0] inj_byte;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [CORES-1:0] r, input int last);
        for (int off = 1; off <= CORES; off++) begin
            if (r[(last + off) % CORES]) return (last + off) % CORES;
        end
        return -1;
    endfunction

    function automatic logic all_empty();
        for (int c = 0; c < CORES; c++) begin
            if (qhead[c] != qtail[c]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drive_reqs();
        for (int c = 0; c < CORES; c++) begin
            req[c] = (qhead[c] != qtail[c]);
            data[c*WIDTH +: WIDTH] = req[c] ? qbuf[c][qhead[c]] : WIDTH'($urandom);
        end
    endtask

    task automatic push(input int c, input logic [WIDTH-1:0] b);
        qbuf[c][qtail[c]] = b;
        qtail[c]++;
        drive_reqs();
    endtask

    task automatic tick();
        logic [CORES-1:0] o_ack;
        logic [CORES-1:0] e_ack;
        logic             o_start;
        logic             e_start;
        int               w;
        @(negedge clk);
        cyc++;
        o_ack   = ack;
        o_start = uart_start;
        e_start = 1'b0;
        e_ack   = '0;
        // inputs still hold the values the DUT sampled at the edge just passed
        if (reset) begin
            m_phase = M_IDLE;
            m_last  = CORES - 1;
            m_err   = 1'b0;
            m_data  = '0;
            m_gid   = 0;
        end else begin
            case (m_phase)
                M_IDLE: begin
                    w = rr_pick(req, m_last);
                    if (w >= 0) begin
                        e_start  = 1'b1;
                        e_ack[w] = 1'b1;
                        m_data   = data[w*WIDTH +: WIDTH];
                        m_gid    = w;
                        m_last   = w;
                        m_phase  = M_WB;
                        m_n      = 0;
                    end
                end
                M_WB: begin
                    m_n++;
                    if (uart_busy) begin
                        m_phase = M_WD;
                    end else if (m_n == BT) begin
                        m_err   = 1'b1;
                        m_phase = M_IDLE;
                    end
                end
                default: begin
                    if (!uart_busy) m_phase = M_IDLE;
                end
            endcase
        end
        chk("uart_start", o_start, e_start);
        chk("ack", o_ack, e_ack);
        chk("active", active, m_phase != M_IDLE);
        chk("timeout_err", timeout_err, m_err);
        chk("grant_id", grant_id, m_gid);
        chk("uart_data_tx", uart_data_tx, m_data);

        if (o_start) begin
            log_core.push_back(int'(grant_id));
            log_byte.push_back(uart_data_tx);
            log_cyc.push_back(cyc);
            start_tick = cyc;
            $display("grant core=%0d byte=%02h cycle=%0d", grant_id, uart_data_tx, cyc);
        end
        if (o_ack != 0) ack_cnt++;
        if (timeout_err && !err_seen) err_tick = cyc;
        err_seen = timeout_err;

        if (bt != 0) bt++;
        else if (o_start && busy_en) bt = 1;
        if (bt > 22) bt = 0;
        uart_busy = (bt >= 3);

        for (int c = 0; c < CORES; c++) begin
            if (o_ack[c] && qhead[c] != qtail[c]) qhead[c]++;
        end
        if (inj_core >= 0 && log_core.size() == inj_at) begin
            qbuf[inj_core][qtail[inj_core]] = inj_byte;
            qtail[inj_core]++;
            inj_core = -1;
        end
        drive_reqs();
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 3000;
        do begin
            tick();
            budget--;
        end while (!(all_empty() && inj_core < 0 && m_phase == M_IDLE && bt == 0) && budget > 0);
        chk({tag, "_bound"}, budget > 0, 1'b1);
    endtask

    task automatic rst_seq();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int               mark;
        int               acks0;
        int               total;
        int               budget;
        int               pcyc;
        logic [WIDTH-1:0] exp2 [5];
        logic [WIDTH-1:0] exp3 [4];
        int               core3 [4];

        reset = 1'b1; req = '0; data = '0; uart_busy = 1'b0;
        busy_en = 1'b1; bt = 0; inj_core = -1; inj_at = 0; inj_byte = '0;
        m_phase = M_IDLE; m_n = 0; m_last = CORES - 1; m_err = 1'b0; m_data = '0; m_gid = 0;
        ack_cnt = 0; err_tick = 0; start_tick = 0; err_seen = 1'b0;
        for (int c = 0; c < CORES; c++) begin
            qhead[c] = 0;
            qtail[c] = 0;
        end
        tick();
        tick();
        reset = 1'b0;
        chk("reset_active", active, 1'b0);
        chk("reset_start", uart_start, 1'b0);

        // single requester
        mark = log_core.size();
        pcyc = cyc;
        push(0, 8'h41);
        drain("single");
        chk("single_count", log_core.size() - mark, 1);
        chk("single_byte", log_byte[mark], 8'h41);
        chk("single_core", log_core[mark], 0);
        chk("single_latency", log_cyc[mark] - pcyc, 1);

        // all four requesting continuously
        rst_seq();
        mark  = log_core.size();
        acks0 = ack_cnt;
        exp2  = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h30};
        push(0, 8'h30); push(0, 8'h30); push(1, 8'h31); push(2, 8'h32); push(3, 8'h33);
        drain("all4");
        chk("all4_count", log_core.size() - mark, 5);
        chk("all4_acks", ack_cnt - acks0, 5);
        for (int i = 0; i < 5; i++) chk($sformatf("all4_byte%0d", i), log_byte[mark+i], exp2[i]);

        // core 2 streaming, core 1 joins after the second byte
        rst_seq();
        mark  = log_core.size();
        exp3  = '{8'h41, 8'h42, 8'h58, 8'h43};
        core3 = '{2, 2, 1, 2};
        inj_core = 1; inj_at = mark + 2; inj_byte = 8'h58;
        push(2, 8'h41); push(2, 8'h42); push(2, 8'h43);
        drain("stream");
        chk("stream_count", log_core.size() - mark, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stream_byte%0d", i), log_byte[mark+i], exp3[i]);
            chk($sformatf("stream_core%0d", i), log_core[mark+i], core3[i]);
        end

        // busy never rises
        rst_seq();
        busy_en = 1'b0;
        mark = log_core.size();
        push(3, 8'h55);
        drain("timeout");
        chk("timeout_core", log_core[mark], 3);
        chk("timeout_delay", err_tick - start_tick, BT);
        chk("timeout_flag", timeout_err, 1'b1);
        busy_en = 1'b1;
        mark = log_core.size();
        push(1, 8'h66);
        drain("after_timeout");
        chk("after_timeout_core", log_core[mark], 1);
        chk("after_timeout_byte", log_byte[mark], 8'h66);
        chk("timeout_sticky", timeout_err, 1'b1);

        // reset while waiting for the transfer to finish
        push(2, 8'h77);
        budget = 200;
        do begin
            tick();
            budget--;
        end while (m_phase != M_WD && budget > 0);
        chk("midreset_reach_wd", budget > 0, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset_active", active, 1'b0);
        chk("midreset_start", uart_start, 1'b0);
        chk("midreset_err", timeout_err, 1'b0);
        chk("midreset_data", uart_data_tx, 8'h00);
        mark = log_core.size();
        push(2, 8'h78); push(0, 8'h79);
        drain("midreset");
        chk("midreset_first_core", log_core[mark], 0);
        chk("midreset_first_byte", log_byte[mark], 8'h79);

        // randomized rounds
        for (int r = 0; r < 6; r++) begin
            rst_seq();
            busy_en = ($urandom_range(3) != 0);
            mark  = log_core.size();
            acks0 = ack_cnt;
            total = 0;
            for (int c = 0; c < CORES; c++) begin
                int n;
                n = $urandom_range(4);
                for (int k = 0; k < n; k++) push(c, WIDTH'($urandom));
                total += n;
            end
            if (total >= 3) begin
                inj_core = $urandom_range(CORES - 1);
                inj_at   = mark + 1;
                inj_byte = WIDTH'($urandom);
                total++;
            end
            drain($sformatf("rand%0d", r));
            chk($sformatf("rand%0d_count", r), log_core.size() - mark, total);
            chk($sformatf("rand%0d_acks", r), ack_cnt - acks0, total);
            busy_en = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
